// File: rtl/adc_decimator.sv
// -----------------------------------------------------------------------------
// adc_decimator
//   ADC capture path running on the ADC sample clock. One offset-binary word
//   is taken per clock and optionally de-randomised. Each frame of `decim`
//   samples is then reduced to one two's-complement result by one of three
//   modes: pick-last, shifted sum (saturated) or signed peak. The result goes
//   out over a valid/ready handshake together with per-frame overrange status
//   and a sticky overrun flag.
//
// Ports
//   clkouta    in   1        ADC sample clock, rising edge
//   rst_n      in   1        async active-low reset
//   en         in   1        1 = capture frames, 0 = idle
//   decim      in   CNT_W    samples per frame (0 acts as 1), latched per frame
//   mode       in   2        0 last, 1 sum>>>shift, 2 peak, 3 behaves as 0
//   shift      in   SHIFT_W  arithmetic right shift for sum mode, latched per frame
//   rand_en    in   1        de-randomise the raw ADC word
//   data_in    in   DATA_W   raw ADC word, offset binary
//   ofa        in   1        ADC overrange flag aligned with data_in
//   out_data   out  DATA_W   frame result, two's complement
//   out_ovf    out  1        overrange seen somewhere in the frame
//   out_valid  out  1        result pending
//   out_ready  in   1        consumer accepts on out_valid && out_ready
//   overrun    out  1        sticky: a result was dropped because the last one was not taken
//   LED        out  8        {out_data[MSB-:3], out_ovf, overrun, out_data[2:0]}
// -----------------------------------------------------------------------------
module adc_decimator #(
   parameter int DATA_W  = 16,
   parameter int CNT_W   = 24,
   parameter int ACC_W   = 40,
   parameter int SHIFT_W = 5
) (
   input  logic               clkouta,
   input  logic               rst_n,
   input  logic               en,
   input  logic [CNT_W-1:0]   decim,
   input  logic [1:0]         mode,
   input  logic [SHIFT_W-1:0] shift,
   input  logic               rand_en,
   input  logic [DATA_W-1:0]  data_in,
   input  logic               ofa,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_ovf,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               overrun,
   output logic [7:0]         LED
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0]         CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]         CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [ACC_W-1:0]         ACC_ZERO = {ACC_W{1'b0}};
   localparam logic [DATA_W-1:0]        PEAK_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0]  SAT_MAX  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0]  SAT_MIN  = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   state_t               state_r, state_nxt_s;
   logic                 start_s, consume_s, last_s, xfer_s;

   logic [CNT_W-1:0]     cnt_r, decim_q_r, decim_eff_s;
   logic [SHIFT_W-1:0]   shift_q_r;
   logic [ACC_W-1:0]     acc_r, acc_sum_s;
   logic [DATA_W-1:0]    peak_r, peak_max_s;
   logic                 ovf_acc_r, ovf_sum_s;

   logic [DATA_W-1:0]    corr_s, sample_s, result_s;
   logic signed [ACC_W-1:0] shifted_s;

   logic [DATA_W-1:0]    out_data_r, out_data_nxt_s;
   logic                 out_ovf_r, out_ovf_nxt_s;
   logic                 out_valid_r, out_valid_nxt_s;
   logic                 overrun_r, overrun_nxt_s;
   logic [7:0]           led_r, led_nxt_s;

   assign out_data  = out_data_r;
   assign out_ovf   = out_ovf_r;
   assign out_valid = out_valid_r;
   assign overrun   = overrun_r;
   assign LED       = led_r;

   // Sample conditioning: optional de-randomisation, then offset binary -> two's complement.
   always_comb begin
      corr_s = data_in;
      if (rand_en) begin
         corr_s = {data_in[DATA_W-1:1] ^ {(DATA_W-1){data_in[0]}}, data_in[0]};
      end else begin
         corr_s = data_in;
      end
      sample_s = {~corr_s[DATA_W-1], corr_s[DATA_W-2:0]};
   end

   // Frame-control FSM state register.
   always_ff @(posedge clkouta or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Frame-control FSM next-state logic; dropping en in RUN abandons the partial frame.
   always_comb begin
      state_nxt_s = state_r;
      start_s     = 1'b0;
      consume_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (en) begin
               state_nxt_s = ST_START;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_START: begin
            start_s     = 1'b1;
            state_nxt_s = ST_RUN;
         end
         ST_RUN: begin
            if (en) begin
               consume_s   = 1'b1;
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Frame datapath: running sum/peak/overrange including the current sample, and the reduced result.
   always_comb begin
      decim_eff_s = (decim == CNT_ZERO) ? CNT_ONE : decim;
      last_s      = consume_s && (cnt_r == (decim_q_r - CNT_ONE));
      acc_sum_s   = acc_r + {{(ACC_W-DATA_W){sample_s[DATA_W-1]}}, sample_s};
      peak_max_s  = ($signed(sample_s) > $signed(peak_r)) ? sample_s : peak_r;
      ovf_sum_s   = ovf_acc_r | ofa;
      shifted_s   = $signed(acc_sum_s) >>> shift_q_r;
      result_s    = sample_s;
      case (mode)
         2'd1: begin
            if (shifted_s > SAT_MAX) begin
               result_s = SAT_MAX[DATA_W-1:0];
            end else if (shifted_s < SAT_MIN) begin
               result_s = SAT_MIN[DATA_W-1:0];
            end else begin
               result_s = shifted_s[DATA_W-1:0];
            end
         end
         2'd2: begin
            result_s = peak_max_s;
         end
         default: begin
            result_s = sample_s;
         end
      endcase
   end

   // Frame state registers: re-armed on START and at every frame boundary so frames run back-to-back.
   always_ff @(posedge clkouta or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r     <= CNT_ZERO;
         decim_q_r <= CNT_ZERO;
         shift_q_r <= {SHIFT_W{1'b0}};
         acc_r     <= ACC_ZERO;
         peak_r    <= PEAK_MIN;
         ovf_acc_r <= 1'b0;
      end else if (start_s || last_s) begin
         cnt_r     <= CNT_ZERO;
         decim_q_r <= decim_eff_s;
         shift_q_r <= shift;
         acc_r     <= ACC_ZERO;
         peak_r    <= PEAK_MIN;
         ovf_acc_r <= 1'b0;
      end else if (consume_s) begin
         cnt_r     <= cnt_r + CNT_ONE;
         acc_r     <= acc_sum_s;
         peak_r    <= peak_max_s;
         ovf_acc_r <= ovf_sum_s;
      end else begin
         cnt_r     <= cnt_r;
         acc_r     <= acc_r;
         peak_r    <= peak_r;
         ovf_acc_r <= ovf_acc_r;
      end
   end

   // Output handshake: a completing frame loads only if the slot is free or being emptied this edge.
   always_comb begin
      out_data_nxt_s  = out_data_r;
      out_ovf_nxt_s   = out_ovf_r;
      out_valid_nxt_s = out_valid_r;
      overrun_nxt_s   = overrun_r;
      xfer_s          = out_valid_r && out_ready;
      if (last_s) begin
         if (!out_valid_r || xfer_s) begin
            out_data_nxt_s  = result_s;
            out_ovf_nxt_s   = ovf_sum_s;
            out_valid_nxt_s = 1'b1;
         end else begin
            overrun_nxt_s   = 1'b1;
         end
      end else if (xfer_s) begin
         out_valid_nxt_s = 1'b0;
      end else begin
         out_valid_nxt_s = out_valid_r;
      end
      led_nxt_s = {out_data_nxt_s[DATA_W-1 -: 3], out_ovf_nxt_s, overrun_nxt_s, out_data_nxt_s[2:0]};
   end

   // Output registers, LED included so it always tracks the registered result.
   always_ff @(posedge clkouta or negedge rst_n) begin
      if (!rst_n) begin
         out_data_r  <= {DATA_W{1'b0}};
         out_ovf_r   <= 1'b0;
         out_valid_r <= 1'b0;
         overrun_r   <= 1'b0;
         led_r       <= 8'h00;
      end else begin
         out_data_r  <= out_data_nxt_s;
         out_ovf_r   <= out_ovf_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         overrun_r   <= overrun_nxt_s;
         led_r       <= led_nxt_s;
      end
   end

endmodule

// File: tb/tb_adc_decimator.sv
module tb_adc_decimator;

   logic        clkouta = 1'b0;
   logic        rst_n;
   logic        en;
   logic [23:0] decim;
   logic [1:0]  mode;
   logic [4:0]  shift;
   logic        rand_en;
   logic [15:0] data_in;
   logic        ofa;
   logic [15:0] out_data;
   logic        out_ovf;
   logic        out_valid;
   logic        out_ready;
   logic        overrun;
   logic [7:0]  LED;

   int checks = 0;
   int errors = 0;
   logic [16:0] exp_q[$];

   adc_decimator dut (
      .clkouta   (clkouta),
      .rst_n     (rst_n),
      .en        (en),
      .decim     (decim),
      .mode      (mode),
      .shift     (shift),
      .rand_en   (rand_en),
      .data_in   (data_in),
      .ofa       (ofa),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun),
      .LED       (LED)
   );

   always #5 clkouta = ~clkouta;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: every accepted transfer is compared with the oldest expected result.
   always @(negedge clkouta) begin
      if (rst_n && out_valid && out_ready) begin
         checks = checks + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_output got ovf=%0b data=%h, none expected", out_ovf, out_data);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            if ({out_ovf, out_data} !== e) begin
               errors = errors + 1;
               $display("FAIL result got ovf=%0b data=%h expected ovf=%0b data=%h",
                        out_ovf, out_data, e[16], e[15:0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clkouta);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic sample(input logic [15:0] d, input logic f);
      data_in = d;
      ofa     = f;
      tick();
   endtask

   // IDLE -> START -> RUN; afterwards every tick consumes one sample.
   task automatic begin_frames();
      en = 1'b1;
      tick();
      tick();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; decim = 24'd4; mode = 2'd0; shift = 5'd0;
      rand_en = 1'b0; data_in = 16'h0000; ofa = 1'b0; out_ready = 1'b1;
      idle(2);
      chk("reset_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_data", {16'd0, out_data}, 32'd0);
      chk("reset_overrun", {31'd0, overrun}, 32'd0);
      chk("reset_ovf", {31'd0, out_ovf}, 32'd0);
      chk("reset_led", {24'd0, LED}, 32'd0);
      rst_n = 1'b1;
      tick();

      // pick-last, decim 4
      decim = 24'd4; mode = 2'd0;
      begin_frames();
      exp_q.push_back({1'b0, 16'h0004});
      sample(16'h8001, 1'b0);
      sample(16'h8002, 1'b0);
      sample(16'h8003, 1'b0);
      chk("t1_valid_early", {31'd0, out_valid}, 32'd0);
      sample(16'h8004, 1'b0);
      en = 1'b0;
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_led", {24'd0, LED}, 32'h04);
      idle(3);

      // sum mode with shift, positive and negative saturation
      mode = 2'd1; shift = 5'd2;
      begin_frames();
      exp_q.push_back({1'b0, 16'h0010});
      for (int i = 0; i < 4; i++) sample(16'h8010, 1'b0);
      en = 1'b0;
      idle(3);
      shift = 5'd0;
      begin_frames();
      exp_q.push_back({1'b0, 16'h7FFF});
      for (int i = 0; i < 4; i++) sample(16'hFFFF, 1'b0);
      en = 1'b0;
      idle(3);
      begin_frames();
      exp_q.push_back({1'b0, 16'h8000});
      for (int i = 0; i < 4; i++) sample(16'h0000, 1'b0);
      en = 1'b0;
      idle(3);

      // signed peak, overrange on one frame only, back-to-back frames
      decim = 24'd3; mode = 2'd2;
      begin_frames();
      exp_q.push_back({1'b1, 16'h1000});
      exp_q.push_back({1'b0, 16'h0002});
      sample(16'h0000, 1'b0);
      sample(16'h9000, 1'b1);
      sample(16'h8100, 1'b0);
      chk("t3_led", {24'd0, LED}, 32'h10);
      sample(16'h8001, 1'b0);
      sample(16'h8002, 1'b0);
      sample(16'h8000, 1'b0);
      en = 1'b0;
      idle(3);

      // de-randomisation, decim 1
      decim = 24'd1; mode = 2'd0; rand_en = 1'b1;
      begin_frames();
      exp_q.push_back({1'b0, 16'h7FFD});
      exp_q.push_back({1'b0, 16'hFFFF});
      sample(16'h0003, 1'b0);
      sample(16'h8001, 1'b0);
      en = 1'b0; rand_en = 1'b0;
      idle(3);

      // decim 0 acts as 1
      decim = 24'd0;
      begin_frames();
      exp_q.push_back({1'b0, 16'h0005});
      exp_q.push_back({1'b0, 16'h0006});
      sample(16'h8005, 1'b0);
      sample(16'h8006, 1'b0);
      en = 1'b0;
      idle(3);

      // overrun: second frame completes while the first is still pending
      decim = 24'd2; out_ready = 1'b0;
      begin_frames();
      exp_q.push_back({1'b0, 16'h0012});
      sample(16'h8011, 1'b0);
      sample(16'h8012, 1'b0);
      sample(16'h8021, 1'b0);
      sample(16'h8022, 1'b0);
      en = 1'b0;
      chk("t5_overrun", {31'd0, overrun}, 32'd1);
      chk("t5_valid_held", {31'd0, out_valid}, 32'd1);
      chk("t5_data_held", {16'd0, out_data}, 32'h0012);
      chk("t5_led", {24'd0, LED}, 32'h0A);
      out_ready = 1'b1;
      idle(3);
      chk("t5_drained", {31'd0, out_valid}, 32'd0);

      // asynchronous reset mid-frame
      decim = 24'd4;
      begin_frames();
      sample(16'h8051, 1'b0);
      sample(16'h8052, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_data", {16'd0, out_data}, 32'd0);
      chk("t6_rst_overrun", {31'd0, overrun}, 32'd0);
      chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_rst_led", {24'd0, LED}, 32'd0);
      en = 1'b0;
      idle(2);
      rst_n = 1'b1;
      tick();
      begin_frames();
      exp_q.push_back({1'b0, 16'h0064});
      sample(16'h8061, 1'b0);
      sample(16'h8062, 1'b0);
      sample(16'h8063, 1'b0);
      chk("t6_valid_early", {31'd0, out_valid}, 32'd0);
      sample(16'h8064, 1'b0);
      en = 1'b0;
      chk("t6_valid", {31'd0, out_valid}, 32'd1);
      idle(3);

      // transfer on the completion edge: new result loads, no overrun
      decim = 24'd2; out_ready = 1'b0;
      begin_frames();
      exp_q.push_back({1'b0, 16'h0042});
      exp_q.push_back({1'b0, 16'h0044});
      sample(16'h8041, 1'b0);
      sample(16'h8042, 1'b0);
      sample(16'h8043, 1'b0);
      out_ready = 1'b1;
      sample(16'h8044, 1'b0);
      en = 1'b0;
      chk("t5b_valid", {31'd0, out_valid}, 32'd1);
      chk("t5b_data", {16'd0, out_data}, 32'h0044);
      chk("t5b_no_overrun", {31'd0, overrun}, 32'd0);
      idle(3);
      chk("t5b_drained", {31'd0, out_valid}, 32'd0);

      // en dropped mid-frame: partial frame discarded, pending result still transferable
      out_ready = 1'b0;
      begin_frames();
      exp_q.push_back({1'b0, 16'h0032});
      sample(16'h8031, 1'b0);
      sample(16'h8032, 1'b0);
      sample(16'h8033, 1'b0);
      en = 1'b0;
      idle(3);
      chk("drop_pending_valid", {31'd0, out_valid}, 32'd1);
      chk("drop_pending_data", {16'd0, out_data}, 32'h0032);
      out_ready = 1'b1;
      idle(4);
      chk("drop_no_partial", {31'd0, out_valid}, 32'd0);
      chk("drop_no_overrun", {31'd0, overrun}, 32'd0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
